// File: rtl/dmem_access_unit.sv
// rtl/dmem_access_unit.sv - data-memory initiator: loads, stores, sub-word read-modify-write
// Optional misalignment trap: define DMEM_MISALIGN_TRAP_EN.
module dmem_access_unit #(
  parameter int MEM_WORDS = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic        memread,
  output logic        memwrite,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state;
  logic        store_q;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;

  logic f3_legal;
  logic range_fault;
  logic misalign;
  logic accept_fault;

  always_comb begin
    f3_legal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = !req_write;
      default:                f3_legal = 1'b0;
    endcase
    range_fault = {2'b00, req_addr[31:2]} >= 32'(MEM_WORDS);
`ifdef DMEM_MISALIGN_TRAP_EN
    misalign = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
               (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
`else
    misalign = 1'b0;
`endif
    accept_fault = !f3_legal || range_fault || misalign;
  end

  // Halfword lane is addr[1] only, so an unaligned halfword silently aligns down.
  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] merge_store(input logic [31:0] word,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  lane,
                                              input logic [15:0] wd);
    logic [31:0] m;
    m = word;
    if (f3[1:0] == 2'b00)
      m[{lane, 3'b000} +: 8] = wd[7:0];
    else if (lane[1])
      m[31:16] = wd;
    else
      m[15:0] = wd;
    return m;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_fault    <= 1'b0;
      resp_rdata    <= 32'h0;
      memread       <= 1'b0;
      memwrite      <= 1'b0;
      mem_address   <= 32'h0;
      mem_writedata <= 32'h0;
      store_q       <= 1'b0;
      funct3_q      <= 3'b000;
      lane_q        <= 2'b00;
      wdata_q       <= 16'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            store_q   <= req_write;
            funct3_q  <= req_funct3;
            lane_q    <= req_addr[1:0];
            wdata_q   <= req_wdata[15:0];
            req_ready <= 1'b0;
            if (accept_fault) begin
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
              resp_rdata <= 32'h0;
              state      <= RESP;
            end else if (req_write && req_funct3 == 3'b010) begin
              memwrite      <= 1'b1;
              mem_address   <= {2'b00, req_addr[31:2]};
              mem_writedata <= req_wdata;
              state         <= WR;
            end else begin
              memread     <= 1'b1;
              mem_address <= {2'b00, req_addr[31:2]};
              state       <= RD;
            end
          end
        end
        RD: begin
          memread <= 1'b0;
          if (store_q) begin
            // Address stays put so the write lands on the word just read.
            mem_writedata <= merge_store(mem_readdata, funct3_q, lane_q, wdata_q);
            memwrite      <= 1'b1;
            state         <= WR;
          end else begin
            resp_rdata  <= extend_load(mem_readdata, funct3_q, lane_q);
            resp_valid  <= 1'b1;
            mem_address <= 32'h0;
            state       <= RESP;
          end
        end
        WR: begin
          memwrite      <= 1'b0;
          mem_address   <= 32'h0;
          mem_writedata <= 32'h0;
          resp_valid    <= 1'b1;
          resp_rdata    <= 32'h0;
          state         <= RESP;
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_fault <= 1'b0;
          resp_rdata <= 32'h0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
